// File: rtl/ztex_readout_pkg.sv
// ztex_readout_pkg: shared widths, output-word field offsets and a constant clog2 helper
//   for the nonce readout stage. No ports.
package ztex_readout_pkg;
    localparam int NONCE_W  = 32;
    localparam int BYTE_W   = 8;
    localparam int OUTBUF_W = 128;
    localparam int GN0_LSB   = 0;
    localparam int NONCE_LSB = 32;
    localparam int HASH_LSB  = 64;
    localparam int GN1_LSB   = 96;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/ztex_sync_edge.sv
// ztex_sync_edge: multi-stage synchronizer; emits either the synchronized level or a
//   debounced any-polarity edge pulse.
//   clk, rst_n : sampling clock, async active-low reset
//   d_i        : asynchronous input
//   q_o        : DEBOUNCE=0 -> synchronized level; DEBOUNCE=1 -> one-cycle edge pulse
module ztex_sync_edge #(
    parameter int STAGES   = 4,
    parameter bit DEBOUNCE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] s_q;

    // s_q[0] holds the newest sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_q <= '0;
        else s_q <= {s_q[STAGES-2:0], d_i};
    end

    generate
        if (DEBOUNCE) begin : g_edge
            // a change only counts once the three older samples agree
            assign q_o = (s_q[3] == s_q[2]) && (s_q[2] == s_q[1]) && (s_q[1] != s_q[0]);
        end else begin : g_level
            assign q_o = s_q[STAGES-1];
        end
    endgenerate
endmodule

// File: rtl/ztex_nonce_readout.sv
// ztex_nonce_readout: queues golden nonces from the cores and serializes a 128-bit
//   status word {gn1, hash, nonce, gn0} to the host one byte per wr_clk edge.
//   hash_clk, reset_n : core clock, async active-low reset
//   clear             : flush the queue and the overflow flag
//   gn_match          : per-core nonce-valid pulse; golden_nonce holds the nonces
//   hash_in, nonce_in : live monitor values sampled during the hold window
//   wr_start, wr_clk  : host read start and byte strobe (asynchronous)
//   write_byte        : registered output byte
//   fifo_count        : queue occupancy; overflow: sticky drop flag
module ztex_nonce_readout
    import ztex_readout_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int NCORES      = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                        hash_clk,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic [NCORES-1:0]           gn_match,
    input  logic [NONCE_W*NCORES-1:0]   golden_nonce,
    input  logic [NONCE_W-1:0]          hash_in,
    input  logic [NONCE_W-1:0]          nonce_in,
    input  logic                        wr_start,
    input  logic                        wr_clk,
    output logic [BYTE_W-1:0]           write_byte,
    output logic [clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                        overflow
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);
    localparam int HW = clog2(HOLD_CYCLES + 1);

    logic                ws, ws_d_q, start_rise, shift_edge, hold;
    logic [HW-1:0]       cnt_q, cnt_d;
    logic [NONCE_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]       rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]       count_q, count_d, pops, acc;
    logic                ovf_q, ovf_d;
    logic [NCORES-1:0]   push_en;
    logic [AW-1:0]       push_addr [NCORES];
    logic [NONCE_W-1:0]  gn0, gn1;
    logic [OUTBUF_W-1:0] outbuf_q, outbuf_d;
    logic [BYTE_W-1:0]   write_byte_q;

    ztex_sync_edge #(.STAGES(2), .DEBOUNCE(1'b0)) u_ws_sync (
        .clk  (hash_clk),
        .rst_n(reset_n),
        .d_i  (wr_start),
        .q_o  (ws)
    );

    ztex_sync_edge #(.STAGES(4), .DEBOUNCE(1'b1)) u_wclk_edge (
        .clk  (hash_clk),
        .rst_n(reset_n),
        .d_i  (wr_clk),
        .q_o  (shift_edge)
    );

    assign start_rise = ws & ~ws_d_q;
    assign hold       = ws | (cnt_q < HW'(HOLD_CYCLES));
    assign cnt_d      = ws ? '0 : (hold ? cnt_q + 1'b1 : cnt_q);

    // Pops happen before pushes are admitted, so a snapshot frees room for this cycle's matches.
    always_comb begin
        pops    = start_rise ? ((count_q >= CW'(2)) ? CW'(2) : count_q) : '0;
        acc     = '0;
        ovf_d   = ovf_q;
        push_en = '0;
        for (int k = 0; k < NCORES; k++) begin
            push_addr[k] = wr_q + AW'(acc);
            if (gn_match[k] && (count_q - pops + acc) < CW'(DEPTH)) begin
                push_en[k] = 1'b1;
                acc        = acc + 1'b1;
            end else if (gn_match[k]) begin
                ovf_d = 1'b1;
            end
        end
        gn0     = (count_q != '0) ? mem_q[rd_q] : '0;
        gn1     = (count_q >= CW'(2)) ? mem_q[rd_q + AW'(1)] : '0;
        rd_d    = rd_q + AW'(pops);
        wr_d    = wr_q + AW'(acc);
        count_d = count_q - pops + acc;
        if (clear) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            push_en = '0;
            gn0     = '0;
            gn1     = '0;
        end
    end

    // The snapshot itself lands inside the hold window, so it must win over the refresh.
    always_comb begin
        outbuf_d = start_rise ? {gn1, hash_in, nonce_in, gn0}
                 : hold       ? {outbuf_q[OUTBUF_W-1:GN1_LSB], hash_in, nonce_in, outbuf_q[NONCE_LSB-1:GN0_LSB]}
                 : shift_edge ? {BYTE_W'(0), outbuf_q[OUTBUF_W-1:BYTE_W]}
                 : outbuf_q;
    end

    always_ff @(posedge hash_clk) begin
        for (int k = 0; k < NCORES; k++)
            if (push_en[k]) mem_q[push_addr[k]] <= golden_nonce[k*NONCE_W +: NONCE_W];
    end

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            ws_d_q       <= 1'b0;
            cnt_q        <= HW'(HOLD_CYCLES);
            rd_q         <= '0;
            wr_q         <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            outbuf_q     <= '0;
            write_byte_q <= '0;
        end else begin
            ws_d_q       <= ws;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            outbuf_q     <= outbuf_d;
            write_byte_q <= outbuf_q[BYTE_W-1:0];
        end
    end

    assign write_byte = write_byte_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_ztex_nonce_readout.sv
// tb_ztex_nonce_readout: randomized bench with a queue-based reference model.
module tb_ztex_nonce_readout;
    localparam int DEPTH = 8;
    localparam int HOLD  = 4;

    logic        hash_clk = 1'b0;
    logic        reset_n, clear, wr_start, wr_clk;
    logic [1:0]  gn_match;
    logic [63:0] golden_nonce;
    logic [31:0] hash_in, nonce_in;
    logic [7:0]  write_byte;
    logic [3:0]  fifo_count;
    logic        overflow;

    logic [31:0] mq[$];
    logic        movf;
    logic [7:0]  rx[16];
    int          checks = 0;
    int          failures = 0;

    ztex_nonce_readout #(.DEPTH(DEPTH), .NCORES(2), .HOLD_CYCLES(HOLD)) dut (
        .hash_clk    (hash_clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .gn_match    (gn_match),
        .golden_nonce(golden_nonce),
        .hash_in     (hash_in),
        .nonce_in    (nonce_in),
        .wr_start    (wr_start),
        .wr_clk      (wr_clk),
        .write_byte  (write_byte),
        .fifo_count  (fifo_count),
        .overflow    (overflow)
    );

    always #5 hash_clk = ~hash_clk;

    task automatic step();
        @(posedge hash_clk);
        @(negedge hash_clk);
    endtask

    task automatic model_push(input logic [1:0] m, input logic [31:0] n0, input logic [31:0] n1);
        if (m[0]) begin
            if (mq.size() < DEPTH) mq.push_back(n0);
            else movf = 1'b1;
        end
        if (m[1]) begin
            if (mq.size() < DEPTH) mq.push_back(n1);
            else movf = 1'b1;
        end
    endtask

    task automatic model_snap(input logic iclr, output logic [127:0] e);
        logic [31:0] g0, g1;
        int n;
        g0 = (!iclr && mq.size() > 0) ? mq[0] : 32'h0;
        g1 = (!iclr && mq.size() > 1) ? mq[1] : 32'h0;
        e  = {g1, hash_in, nonce_in, g0};
        if (iclr) begin
            mq.delete();
            movf = 1'b0;
        end else begin
            n = (mq.size() > 2) ? 2 : mq.size();
            repeat (n) void'(mq.pop_front());
        end
    endtask

    task automatic match(input logic [1:0] m, input logic [31:0] n0, input logic [31:0] n1);
        gn_match = m;
        golden_nonce = {n1, n0};
        step();
        gn_match = '0;
        model_push(m, n0, n1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        mq.delete();
        movf = 1'b0;
    endtask

    // Full host read; im/i0/i1/iclr are applied in the snapshot cycle (two syncs after wr_start).
    task automatic host_read(input logic [1:0] im, input logic [31:0] i0, input logic [31:0] i1,
                             input logic iclr, output logic [127:0] e);
        model_snap(iclr, e);
        if (!iclr) model_push(im, i0, i1);
        wr_start = 1'b1;
        step();
        step();
        gn_match = im;
        golden_nonce = {i1, i0};
        clear = iclr;
        step();
        gn_match = '0;
        clear = 1'b0;
        step();
        wr_start = 1'b0;
        repeat (HOLD + 4) step();
        for (int i = 0; i < 16; i++) begin
            rx[i] = write_byte;
            if (i < 15) begin
                wr_clk = ~wr_clk;
                repeat (5) step();
            end
        end
    endtask

    task automatic test_reset();
        checks += 3;
        if (write_byte !== 8'h00) begin failures++; $display("FAIL reset_byte got=%h exp=00", write_byte); end
        if (fifo_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        reset_n = 1'b1;
        repeat (3) step();
        checks += 2;
        if (write_byte !== 8'h00) begin failures++; $display("FAIL post_reset_byte got=%h exp=00", write_byte); end
        if (fifo_count !== 4'd0) begin failures++; $display("FAIL post_reset_count got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_empty_read();
        logic [127:0] e;
        hash_in = $urandom;
        nonce_in = $urandom;
        host_read(2'b00, 32'h0, 32'h0, 1'b0, e);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rx[i] !== e[8*i +: 8]) begin failures++; $display("FAIL empty_byte%0d got=%h exp=%h", i, rx[i], e[8*i +: 8]); end
        end
        checks++;
        if (fifo_count !== 4'd0) begin failures++; $display("FAIL empty_count got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_single();
        logic [127:0] e;
        match(2'b01, 32'h0000318f, 32'h0);
        checks++;
        if (fifo_count !== 4'd1) begin failures++; $display("FAIL single_count_pre got=%0d exp=1", fifo_count); end
        hash_in = $urandom;
        nonce_in = $urandom;
        host_read(2'b00, 32'h0, 32'h0, 1'b0, e);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rx[i] !== e[8*i +: 8]) begin failures++; $display("FAIL single_byte%0d got=%h exp=%h", i, rx[i], e[8*i +: 8]); end
        end
        checks++;
        if (fifo_count !== 4'd0) begin failures++; $display("FAIL single_count_post got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_dual();
        logic [127:0] e;
        match(2'b11, 32'h11111111, 32'h22222222);
        checks++;
        if (fifo_count !== 4'd2) begin failures++; $display("FAIL dual_count_pre got=%0d exp=2", fifo_count); end
        hash_in = $urandom;
        nonce_in = $urandom;
        host_read(2'b00, 32'h0, 32'h0, 1'b0, e);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rx[i] !== e[8*i +: 8]) begin failures++; $display("FAIL dual_byte%0d got=%h exp=%h", i, rx[i], e[8*i +: 8]); end
        end
        checks++;
        if (fifo_count !== 4'd0) begin failures++; $display("FAIL dual_count_post got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_overflow();
        logic [127:0] e;
        for (int i = 0; i < 9; i++) match(2'b01, $urandom, 32'h0);
        checks += 2;
        if (fifo_count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", fifo_count); end
        if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        for (int r = 0; r < 4; r++) begin
            hash_in = $urandom;
            nonce_in = $urandom;
            host_read(2'b00, 32'h0, 32'h0, 1'b0, e);
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (rx[i] !== e[8*i +: 8]) begin failures++; $display("FAIL ovf_drain%0d_byte%0d got=%h exp=%h", r, i, rx[i], e[8*i +: 8]); end
            end
            checks++;
            if (fifo_count !== 4'(mq.size())) begin failures++; $display("FAIL ovf_drain%0d_count got=%0d exp=%0d", r, fifo_count, mq.size()); end
        end
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        match(2'b11, $urandom, $urandom);
        do_clear();
        checks += 2;
        if (fifo_count !== 4'd0) begin failures++; $display("FAIL clear_count got=%0d exp=0", fifo_count); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL clear_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] e;
        do_clear();
        for (int i = 0; i < 8; i++) match(2'b01, $urandom, 32'h0);
        hash_in = $urandom;
        nonce_in = $urandom;
        host_read(2'b01, $urandom, 32'h0, 1'b0, e);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rx[i] !== e[8*i +: 8]) begin failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, rx[i], e[8*i +: 8]); end
        end
        checks += 2;
        if (fifo_count !== 4'd7) begin failures++; $display("FAIL b2b_count got=%0d exp=7", fifo_count); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_ovf got=%b exp=0", overflow); end
        host_read(2'b11, $urandom, $urandom, 1'b1, e);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rx[i] !== e[8*i +: 8]) begin failures++; $display("FAIL clrsnap_byte%0d got=%h exp=%h", i, rx[i], e[8*i +: 8]); end
        end
        checks++;
        if (fifo_count !== 4'd0) begin failures++; $display("FAIL clrsnap_count got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_hold();
        logic [127:0] e;
        match(2'b01, $urandom, 32'h0);
        hash_in = $urandom;
        nonce_in = $urandom;
        model_snap(1'b0, e);
        wr_start = 1'b1;
        repeat (4) step();
        wr_clk = ~wr_clk;
        repeat (5) step();
        checks++;
        if (write_byte !== e[7:0]) begin failures++; $display("FAIL hold_ws got=%h exp=%h", write_byte, e[7:0]); end
        wr_start = 1'b0;
        repeat (4) step();
        wr_clk = ~wr_clk;
        repeat (8) step();
        checks++;
        if (write_byte !== e[7:0]) begin failures++; $display("FAIL hold_tail got=%h exp=%h", write_byte, e[7:0]); end
        wr_clk = ~wr_clk;
        repeat (5) step();
        checks++;
        if (write_byte !== e[15:8]) begin failures++; $display("FAIL first_shift got=%h exp=%h", write_byte, e[15:8]); end
        wr_clk = ~wr_clk;
        step();
        wr_clk = ~wr_clk;
        step();
        wr_clk = ~wr_clk;
        repeat (6) step();
        checks++;
        if (write_byte !== e[23:16]) begin failures++; $display("FAIL bounce got=%h exp=%h", write_byte, e[23:16]); end
        #1 wr_clk = ~wr_clk;
        #2 wr_clk = ~wr_clk;
        repeat (6) step();
        checks++;
        if (write_byte !== e[23:16]) begin failures++; $display("FAIL glitch got=%h exp=%h", write_byte, e[23:16]); end
        wr_clk = ~wr_clk;
        repeat (5) step();
        checks++;
        if (write_byte !== e[31:24]) begin failures++; $display("FAIL after_glitch got=%h exp=%h", write_byte, e[31:24]); end
        hash_in = $urandom;
        nonce_in = $urandom;
        model_snap(1'b0, e);
        wr_start = 1'b1;
        repeat (4) step();
        wr_start = 1'b0;
        repeat (5) step();
        wr_clk = ~wr_clk;
        repeat (6) step();
        checks++;
        if (write_byte !== e[15:8]) begin failures++; $display("FAIL hold_exit_edge got=%h exp=%h", write_byte, e[15:8]); end
    endtask

    task automatic test_random();
        logic [127:0] e;
        int n;
        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(0, 6);
            for (int j = 0; j < n; j++) match(2'($urandom_range(0, 3)), $urandom, $urandom);
            if ($urandom_range(0, 7) == 0) do_clear();
            checks += 2;
            if (fifo_count !== 4'(mq.size())) begin failures++; $display("FAIL rnd%0d_count_pre got=%0d exp=%0d", it, fifo_count, mq.size()); end
            if (overflow !== movf) begin failures++; $display("FAIL rnd%0d_ovf_pre got=%b exp=%b", it, overflow, movf); end
            hash_in = $urandom;
            nonce_in = $urandom;
            host_read(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(0, 5) == 0, e);
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (rx[i] !== e[8*i +: 8]) begin failures++; $display("FAIL rnd%0d_byte%0d got=%h exp=%h", it, i, rx[i], e[8*i +: 8]); end
            end
            checks += 2;
            if (fifo_count !== 4'(mq.size())) begin failures++; $display("FAIL rnd%0d_count got=%0d exp=%0d", it, fifo_count, mq.size()); end
            if (overflow !== movf) begin failures++; $display("FAIL rnd%0d_ovf got=%b exp=%b", it, overflow, movf); end
        end
    endtask

    task automatic test_async_reset();
        logic [127:0] e;
        for (int i = 0; i < 5; i++) match(2'b11, $urandom, $urandom);
        hash_in = $urandom | 32'h01010101;
        nonce_in = $urandom | 32'h01010101;
        model_snap(1'b0, e);
        wr_start = 1'b1;
        repeat (4) step();
        wr_start = 1'b0;
        repeat (HOLD + 4) step();
        for (int i = 0; i < 5; i++) begin
            wr_clk = ~wr_clk;
            repeat (5) step();
        end
        checks += 2;
        if (write_byte !== e[47:40]) begin failures++; $display("FAIL pre_reset_byte got=%h exp=%h", write_byte, e[47:40]); end
        if (overflow !== 1'b1) begin failures++; $display("FAIL pre_reset_ovf got=%b exp=1", overflow); end
        #2 reset_n = 1'b0;
        #1;
        checks += 3;
        if (write_byte !== 8'h00) begin failures++; $display("FAIL async_byte got=%h exp=00", write_byte); end
        if (fifo_count !== 4'd0) begin failures++; $display("FAIL async_count got=%0d exp=0", fifo_count); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL async_ovf got=%b exp=0", overflow); end
        mq.delete();
        movf = 1'b0;
        @(negedge hash_clk);
        reset_n = 1'b1;
        repeat (3) step();
    endtask

    initial begin
        reset_n = 1'b0;
        clear = 1'b0;
        wr_start = 1'b0;
        wr_clk = 1'b0;
        gn_match = '0;
        golden_nonce = '0;
        hash_in = '0;
        nonce_in = '0;
        movf = 1'b0;
        repeat (3) step();
        test_reset();
        test_empty_read();
        test_single();
        test_dual();
        test_overflow();
        test_back_to_back();
        test_hold();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
